// File: rtl/i2so_serializer.sv
// rtl/i2so_serializer.sv - I2S output serializer: buffers one L/R pair and shifts it out MSB-first
// framed by word select, advancing one slot per sck_transition pulse.
module i2so_serializer #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_transition,
  input  logic              filt_i2so_rts,
  input  logic [WORD_W-1:0] filt_i2so_lft,
  input  logic [WORD_W-1:0] filt_i2so_rgt,
  output logic              filt_i2so_rtr,
  output logic              i2so_sd,
  output logic              i2so_ws
);

  localparam int FRAME = 2 * WORD_W;
  localparam int CW    = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] HALF = CW'(WORD_W);

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [FRAME-1:0]  shreg;
  logic [WORD_W-1:0] hold_l;
  logic [WORD_W-1:0] hold_r;
  logic              hold_valid;
  logic              frame_start;

  assign cnt_nxt     = (cnt == LAST) ? '0 : cnt + CW'(1);
  assign frame_start = sck_transition && (cnt_nxt == '0);

  // rst_n gates the strobe so nothing is acknowledged while held in reset.
  assign filt_i2so_rtr = filt_i2so_rts & ~hold_valid & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= LAST;
      shreg      <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      hold_valid <= 1'b0;
      i2so_ws    <= 1'b0;
      i2so_sd    <= 1'b0;
    end else begin
      if (sck_transition) begin
        cnt     <= cnt_nxt;
        // sd takes the outgoing MSB before any load, giving the one-slot I2S delay.
        i2so_sd <= shreg[FRAME-1];
        if (cnt_nxt == '0) begin
          shreg   <= hold_valid ? {hold_l, hold_r} : '0;
          i2so_ws <= 1'b0;
        end else begin
          shreg <= {shreg[FRAME-2:0], 1'b0};
          if (cnt_nxt == HALF) i2so_ws <= 1'b1;
        end
      end
      // Capture wins over the frame-start clear; the load above already used the old hold.
      if (filt_i2so_rtr) begin
        hold_l     <= filt_i2so_lft;
        hold_r     <= filt_i2so_rgt;
        hold_valid <= 1'b1;
      end else if (frame_start) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2so_serializer.sv
// tb/tb_i2so_serializer.sv - self-checking bench for i2so_serializer: slot-level reference model,
// table of pairs with expected frames, mid-frame reset and randomized sck/rts timing.
module tb_i2so_serializer;
  localparam int W = 16;
  localparam int F = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck = 1'b0;
  logic          rts = 1'b0;
  logic [W-1:0]  lft = '0;
  logic [W-1:0]  rgt = '0;
  logic          rtr, sd, ws;

  i2so_serializer #(.WORD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .sck_transition(sck), .filt_i2so_rts(rts),
    .filt_i2so_lft(lft), .filt_i2so_rgt(rgt),
    .filt_i2so_rtr(rtr), .i2so_sd(sd), .i2so_ws(ws)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lft;
    logic [15:0] rgt;
    int          gap;
    logic [31:0] frame;
  } vec_t;

  typedef struct {
    logic [15:0] lft;
    logic [15:0] rgt;
    int          gap;
  } src_t;

  vec_t        vecs[14];
  src_t        src[$];
  logic [31:0] exp_frames[$];
  logic [31:0] rx_frames[$];
  logic [31:0] pend[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: slot index, frame being sent, previous frame's right LSB.
  int          slot;
  logic [31:0] cur;
  bit          cur_real, prev_real;
  logic        prev_lsb, ws_exp;
  logic [31:0] rx_acc;
  int          sck_period, tick, gap_cnt, frames_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic exp_rtr();
    return rst_n & rts & (pend.size() == 0);
  endfunction

  task automatic model_reset();
    pend.delete();
    slot = F - 1; cur = '0; cur_real = 0; prev_real = 0;
    prev_lsb = 1'b0; ws_exp = 1'b0; rx_acc = '0; tick = 0;
  endtask

  task automatic add(input logic [15:0] l, input logic [15:0] r, input int gap,
                     input logic [31:0] frame, input bit keep);
    if (src.size() == 0) gap_cnt = gap;
    src.push_back('{l, r, gap});
    if (keep) exp_frames.push_back(frame);
  endtask

  task automatic step();
    logic cap;
    rts = (src.size() > 0) && (gap_cnt == 0);
    if (rts) begin lft = src[0].lft; rgt = src[0].rgt; end
    @(negedge clk);
    cap = exp_rtr();
    check("rtr", {31'd0, rtr}, {31'd0, cap});
    @(posedge clk);
    if (sck) begin
      slot = (slot + 1) % F;
      if (slot == 0) begin
        prev_lsb  = cur[0];
        prev_real = cur_real;
        if (pend.size() > 0) begin cur = pend.pop_front(); cur_real = 1; end
        else begin cur = '0; cur_real = 0; end
        ws_exp = 1'b0;
        frames_seen++;
      end else if (slot == W) begin
        ws_exp = 1'b1;
      end
    end
    if (cap) begin
      pend.push_back({lft, rgt});
      void'(src.pop_front());
      gap_cnt = (src.size() > 0) ? src[0].gap : 0;
      frames_seen = 0;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    #1;
    check("sd", {31'd0, sd}, {31'd0, (slot == 0) ? prev_lsb : cur[F-slot]});
    check("ws", {31'd0, ws}, {31'd0, ws_exp});
    if (sck) begin
      rx_acc = {rx_acc[30:0], sd};
      if (slot == 0 && prev_real) rx_frames.push_back(rx_acc);
    end
    if (sck_period > 0) begin
      tick = (tick + 1) % sck_period;
      sck  = (tick == 0);
    end else begin
      sck = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic run(input int max_cycles);
    int n = 0;
    frames_seen = 0;
    while ((src.size() > 0 || frames_seen < 2) && n < max_cycles) begin
      step();
      n++;
    end
    check("run_budget", {31'd0, n < max_cycles}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 16'hFFFF, 0,    32'h0000FFFF};
    vecs[1]  = '{16'hFF00, 16'h00FF, 0,    32'hFF0000FF};
    vecs[2]  = '{16'hAAAA, 16'h5555, 0,    32'hAAAA5555};
    vecs[3]  = '{16'h7398, 16'hFFDD, 6000, 32'h7398FFDD};
    vecs[4]  = '{16'h0000, 16'hFFFF, 0,    32'h0000FFFF};
    vecs[5]  = '{16'h8000, 16'h0001, 0,    32'h80000001};
    vecs[6]  = '{16'h7FFF, 16'h8000, 5,    32'h7FFF8000};
    vecs[7]  = '{16'h1234, 16'hABCD, 0,    32'h1234ABCD};
    vecs[8]  = '{16'h0F0F, 16'hF0F0, 40,   32'h0F0FF0F0};
    vecs[9]  = '{16'hDEAD, 16'hBEEF, 0,    32'hDEADBEEF};
    vecs[10] = '{16'h0001, 16'h8000, 0,    32'h00018000};
    vecs[11] = '{16'hCAFE, 16'hF00D, 1,    32'hCAFEF00D};
    vecs[12] = '{16'h5A5A, 16'hA5A5, 0,    32'h5A5AA5A5};
    vecs[13] = '{16'h99C5, 16'h7435, 0,    32'h99C57435};

    // Reset state with rts already high: strobe must stay low.
    rts = 1'b1;
    #12;
    check("reset_rtr", {31'd0, rtr}, 32'd0);
    check("reset_sd",  {31'd0, sd},  32'd0);
    check("reset_ws",  {31'd0, ws},  32'd0);

    // Fixed 80-clk serial clock: basic frames, back-to-back pairs, one-frame rts gap.
    model_reset();
    sck_period = 80;
    for (int i = 0; i < 4; i++) add(vecs[i].lft, vecs[i].rgt, vecs[i].gap, vecs[i].frame, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(60000);

    // Mid-right-word reset: the in-flight frame and its successor are discarded.
    add(16'h1357, 16'h2468, 0, 32'h0, 0);
    add(16'h4321, 16'h8765, 0, 32'h0, 0);
    begin
      int n = 0;
      while (!(cur_real && slot == 20) && n < 8000) begin step(); n++; end
      check("reach_mid_frame", {31'd0, n < 8000}, 32'd1);
    end
    rst_n = 1'b0;
    rts = 1'b1;
    #1;
    check("midrst_ws",  {31'd0, ws},  32'd0);
    check("midrst_sd",  {31'd0, sd},  32'd0);
    check("midrst_rtr", {31'd0, rtr}, 32'd0);
    src.delete();
    model_reset();
    sck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("inrst_rtr", {31'd0, rtr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    add(16'hC3C3, 16'h3C3C, 0, 32'hC3C33C3C, 1);

    // Randomized serial-clock spacing (including back-to-back pulses) and rts gaps.
    sck_period = 0;
    for (int i = 4; i < 14; i++) add(vecs[i].lft, vecs[i].rgt, vecs[i].gap, vecs[i].frame, 1);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] l, r;
      l = 16'($urandom);
      r = 16'($urandom);
      add(l, r, $urandom_range(0, 150), {l, r}, 1);
    end
    run(60000);

    check("frame_count", rx_frames.size(), exp_frames.size());
    for (int i = 0; i < exp_frames.size() && i < rx_frames.size(); i++)
      check("frame_data", rx_frames[i], exp_frames[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
